// File: rtl/led_pkg.sv
// Shared definitions for the LED row-scan sequencer: FSM state encoding and
// default geometry/timing values used as parameter defaults by the top level.
package led_pkg;

    localparam int ROW_W_DEF         = 6;
    localparam int NUM_ROWS_DEF      = 32;
    localparam int BRIGHT_W_DEF      = 8;
    localparam int ON_SHIFT_DEF      = 2;
    localparam int BLANK_CYCLES_DEF  = 4;
    localparam int SETTLE_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ON     = 2'd3
    } state_e;

endpackage

// File: rtl/led_dwell_counter.sv
// Loadable down-counter timing the BLANK, SETTLE and ON dwell periods.
// Ports:
//   i2s_clk  - clock, rising edge
//   rst_n    - asynchronous active-low reset (count clears to 0)
//   load     - load load_val this cycle (wins over dec)
//   load_val - value to load
//   dec      - decrement by one; holds at zero
//   zero     - count is zero
module led_dwell_counter #(
    parameter int W = 10
) (
    input  logic         i2s_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_row_scan_ctrl.sv
// Row-scan / output-enable sequencer. On each row latch pulse it blanks the
// panel, switches the row address, lets it settle, then lights the row for a
// brightness-scaled dwell.
// Ports:
//   i2s_clk, rst_n  - clock and asynchronous active-low reset
//   lat_in          - 1-cycle row latch pulse; row_in/brightness valid with it
//   row_addr        - registered row address to the panel drivers
//   led_oe          - registered output enable, active low (1 = dark)
//   busy            - sequencer not idle
//   row_done        - pulse: row completed its full on-time
//   frame_start     - pulse: valid latch of row 0
//   overrun         - pulse: latch arrived while busy, current row aborted
//   row_err         - pulse: latch with out-of-range row number
module led_row_scan_ctrl
    import led_pkg::*;
#(
    parameter int ROW_W         = ROW_W_DEF,
    parameter int NUM_ROWS      = NUM_ROWS_DEF,
    parameter int BRIGHT_W      = BRIGHT_W_DEF,
    parameter int ON_SHIFT      = ON_SHIFT_DEF,
    parameter int BLANK_CYCLES  = BLANK_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                i2s_clk,
    input  logic                rst_n,
    input  logic                lat_in,
    input  logic [ROW_W-1:0]    row_in,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [ROW_W-1:0]    row_addr,
    output logic                led_oe,
    output logic                busy,
    output logic                row_done,
    output logic                frame_start,
    output logic                overrun,
    output logic                row_err
);

    localparam int CNT_W = BRIGHT_W + ON_SHIFT;
    localparam logic [ROW_W:0] NUM_ROWS_L = (ROW_W+1)'(NUM_ROWS);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    pend_row_q, pend_row_d;
    logic [BRIGHT_W-1:0] pend_bright_q, pend_bright_d;
    logic [ROW_W-1:0]    row_addr_q, row_addr_d;
    logic                led_oe_q, led_oe_d;
    logic                row_done_q, row_done_d;
    logic                frame_start_q, frame_start_d;
    logic                overrun_q, overrun_d;
    logic                row_err_q, row_err_d;

    logic                cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]    cnt_val;
    logic [CNT_W-1:0]    on_time;
    logic                row_valid;

    // Full-width product; with CNT_W = BRIGHT_W+ON_SHIFT the shift cannot overflow.
    assign on_time   = {pend_bright_q, {ON_SHIFT{1'b0}}};
    assign row_valid = ({1'b0, row_in} < NUM_ROWS_L);

    led_dwell_counter #(.W(CNT_W)) u_dwell (
        .i2s_clk  (i2s_clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d       = state_q;
        pend_row_d    = pend_row_q;
        pend_bright_d = pend_bright_q;
        row_addr_d    = row_addr_q;
        led_oe_d      = led_oe_q;
        row_done_d    = 1'b0;
        frame_start_d = 1'b0;
        overrun_d     = 1'b0;
        row_err_d     = 1'b0;
        cnt_load      = 1'b0;
        cnt_val       = '0;
        cnt_dec       = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_zero) begin
                    row_addr_d = pend_row_q;
                    state_d    = ST_SETTLE;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    if (pend_bright_q == '0) begin
                        // Zero brightness: row is "done" without ever lighting.
                        state_d    = ST_IDLE;
                        row_done_d = 1'b1;
                    end else begin
                        led_oe_d = 1'b0;
                        state_d  = ST_ON;
                        cnt_load = 1'b1;
                        cnt_val  = on_time - CNT_W'(1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_zero) begin
                    led_oe_d   = 1'b1;
                    row_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: ;
        endcase

        // A latch overrides whatever the current state was doing: the panel is
        // blanked at once and any in-flight row is abandoned (no row_done, and
        // no address switch even if BLANK was about to expire).
        if (lat_in) begin
            overrun_d  = (state_q != ST_IDLE);
            led_oe_d   = 1'b1;
            row_done_d = 1'b0;
            row_addr_d = row_addr_q;
            cnt_dec    = 1'b0;
            if (row_valid) begin
                pend_row_d    = row_in;
                pend_bright_d = brightness;
                state_d       = ST_BLANK;
                cnt_load      = 1'b1;
                cnt_val       = CNT_W'(BLANK_CYCLES - 1);
                frame_start_d = (row_in == '0);
            end else begin
                state_d   = ST_IDLE;
                row_err_d = 1'b1;
                cnt_load  = 1'b0;
                cnt_val   = '0;
            end
        end
    end

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pend_row_q    <= '0;
            pend_bright_q <= '0;
            row_addr_q    <= '0;
            led_oe_q      <= 1'b1;
            row_done_q    <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            row_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_row_q    <= pend_row_d;
            pend_bright_q <= pend_bright_d;
            row_addr_q    <= row_addr_d;
            led_oe_q      <= led_oe_d;
            row_done_q    <= row_done_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            row_err_q     <= row_err_d;
        end
    end

    assign row_addr    = row_addr_q;
    assign led_oe      = led_oe_q;
    assign busy        = (state_q != ST_IDLE);
    assign row_done    = row_done_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;
    assign row_err     = row_err_q;

endmodule

// File: tb/tb_led_row_scan_ctrl.sv
// Bench for led_row_scan_ctrl: each accepted row pushes its expected
// completion (row, done edge, lit cycles) to a queue; the monitor pops and
// compares when row_done fires.
module tb_led_row_scan_ctrl;

    logic       i2s_clk = 1'b0;
    logic       rst_n;
    logic       lat_in;
    logic [5:0] row_in;
    logic [7:0] brightness;
    logic [5:0] row_addr;
    logic       led_oe, busy, row_done, frame_start, overrun, row_err;

    led_row_scan_ctrl dut (
        .i2s_clk     (i2s_clk),
        .rst_n       (rst_n),
        .lat_in      (lat_in),
        .row_in      (row_in),
        .brightness  (brightness),
        .row_addr    (row_addr),
        .led_oe      (led_oe),
        .busy        (busy),
        .row_done    (row_done),
        .frame_start (frame_start),
        .overrun     (overrun),
        .row_err     (row_err)
    );

    always #5 i2s_clk = ~i2s_clk;

    typedef struct {
        int row;
        int done_edge;
        int on_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   e0    = 0;
    int   onc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic [5:0] prev_addr = '0;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge i2s_clk) cyc <= cyc + 1;

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge i2s_clk) begin
        exp_t e;
        #1;
        if (!led_oe) onc++;
        if (row_addr != prev_addr) chk("oe_dark_at_addr_chg", led_oe, 1);
        prev_addr = row_addr;
        if (row_done) begin
            chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_row_addr", row_addr, e.row);
                chk("done_edge", cyc, e.done_edge);
                chk("on_cycles", onc, e.on_cyc);
                chk("oe_dark_after_done", led_oe, 1);
            end
        end
    end

    // Advance to the sample point just after edge n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge i2s_clk);
            #1;
        end
    endtask

    // Drive a one-cycle latch; must be called at a sample point.
    task automatic send(input int row, input int br);
        exp_t e;
        bit ovr, valid;
        ovr   = (sb.size() > 0);
        valid = (row < 32);
        lat_in     = 1'b1;
        row_in     = 6'(row);
        brightness = 8'(br);
        @(posedge i2s_clk);
        #1;
        e0 = cyc;
        lat_in     = 1'b0;
        row_in     = 6'($urandom);
        brightness = 8'($urandom);
        onc = 0;
        chk("overrun", overrun, ovr ? 1 : 0);
        chk("row_err", row_err, valid ? 0 : 1);
        chk("frame_start", frame_start, (valid && row == 0) ? 1 : 0);
        chk("oe_blank_at_lat", led_oe, 1);
        if (ovr) void'(sb.pop_front());
        if (valid) begin
            e.row       = row;
            e.done_edge = e0 + 6 + br * 4;
            e.on_cyc    = br * 4;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(posedge i2s_clk);
            #1;
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        goto(cyc + 2);
    endtask

    initial begin
        rst_n = 1'b0; lat_in = 1'b0; row_in = '0; brightness = '0;
        #23;
        chk("rst_oe", led_oe, 1);
        chk("rst_addr", row_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {row_done, frame_start, overrun, row_err}, 0);
        @(negedge i2s_clk) rst_n = 1'b1;
        goto(cyc + 2);

        // 1: row 5, brightness 3
        send(5, 3);
        chk("t1_busy", busy, 1);
        goto(e0 + 3); chk("t1_addr_e3", row_addr, 0);
        goto(e0 + 4); chk("t1_addr_e4", row_addr, 5);
        goto(e0 + 5); chk("t1_oe_e5", led_oe, 1);
        goto(e0 + 6); chk("t1_oe_e6", led_oe, 0);
        goto(e0 + 17); chk("t1_oe_e17", led_oe, 0);
        goto(e0 + 18); chk("t1_oe_e18", led_oe, 1);
        chk("t1_busy_e18", busy, 0);
        chk("t1_done_e18", row_done, 1);
        goto(e0 + 19); chk("t1_done_e19", row_done, 0);
        drain();

        // 2: row 0, brightness 1 -> frame_start, 4 lit cycles
        send(0, 1);
        goto(e0 + 1); chk("t2_fs_clear", frame_start, 0);
        drain();

        // 3: brightness 0 keeps the panel dark
        send(7, 0);
        goto(e0 + 4); chk("t3_addr", row_addr, 7);
        goto(e0 + 5); chk("t3_oe_e5", led_oe, 1);
        goto(e0 + 6); chk("t3_oe_e6", led_oe, 1);
        chk("t3_done", row_done, 1);
        drain();

        // 4: row 9 overruns row 3 eight cycles into its ON phase
        send(3, 4);
        goto(e0 + 13);
        chk("t4_on_before", led_oe, 0);
        send(9, 2);
        goto(e0 + 3); chk("t4_addr_hold", row_addr, 3);
        goto(e0 + 4); chk("t4_addr_new", row_addr, 9);
        drain();

        // 5: out-of-range row while idle, then while ON
        send(40, 5);
        chk("t5_addr_idle", row_addr, 9);
        chk("t5_busy_idle", busy, 0);
        send(2, 5);
        goto(e0 + 8);
        chk("t5_on", led_oe, 0);
        send(40, 1);
        chk("t5_addr_on", row_addr, 2);
        chk("t5_busy_on", busy, 0);
        goto(e0 + 30);
        chk("t5_sb_empty", sb.size(), 0);

        // held latch: every cycle restarts BLANK, overrun on each restart
        send(4, 1);
        send(4, 1);
        send(4, 1);
        drain();

        // 6: asynchronous reset mid-ON
        send(6, 8);
        goto(e0 + 10);
        chk("t6_on", led_oe, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_oe", led_oe, 1);
        chk("t6_rst_addr", row_addr, 0);
        chk("t6_rst_busy", busy, 0);
        sb.delete();
        @(negedge i2s_clk) rst_n = 1'b1;
        goto(cyc + 2);
        send(11, 2);
        goto(e0 + 4); chk("t6_addr_after", row_addr, 11);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        chk("watchdog", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
